debugger_core: RTL and testbench
================================

Name: debugger_core

Overview:
- Byte-wide trigger unit for the Ethernet debug path.
- Watches an 8-bit observation bus `w` each clock and compares it against a masked pattern.
- When the match holds for a qualifying number of cycles, it emits a one-cycle `trigger` pulse and latches the matching byte on `data` for the capture/transmit logic downstream.

Parameters:
- PATTERN, 8'h20, compare value.
- MASK, 8'hFF, bit enable for the compare; 1 = bit compared, 0 = don't care.
- MATCH_LEN, 1, consecutive matching cycles required to fire; legal range 1..255.
- HOLDOFF, 4, cycles after a trigger during which no new trigger may fire; legal range 0..255.

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-low reset; asserted when 0.
- w, input, 8, observed byte, sampled every rising edge.
- trigger, output, 1, registered one-cycle pulse on a qualified match.
- data, output, 8, registered byte captured at the trigger; held until the next trigger.

Behaviour:
- Reset (reset==0, asynchronous): trigger=0, data=8'h00, match counter=0, holdoff counter=0, state=ARMED. Outputs stay at these values while reset is low.
- Match condition: `(w & MASK) == (PATTERN & MASK)`, evaluated on `w` at each rising edge.
- State machine states: ARMED, HOLD, WAIT_CLEAR.
- ARMED:
  - On a match, the counter increments (saturating at MATCH_LEN); on a non-match, the counter clears to 0.
  - When the counter reaches MATCH_LEN on edge k: trigger=1 and data=w(k) after edge k. Latency is 1 clock from the qualifying sample.
  - Next state: HOLD, or WAIT_CLEAR if HOLDOFF==0.
- trigger is high for exactly one cycle and returns to 0 on the next edge.
- HOLD:
  - Holdoff counter counts HOLDOFF edges; `w` is ignored and no trigger fires.
  - After the count completes, go to WAIT_CLEAR.
- WAIT_CLEAR:
  - Stays until one non-match sample, then goes to ARMED with the counter cleared.
  - A static matching level therefore fires only once. A match that appears in the same edge as the exit is not counted.
- data changes only on a trigger edge or on reset.
- Reset mid-operation: immediately returns every register to its reset value, including an in-flight trigger pulse.
- MATCH_LEN==1 and a one-cycle match while ARMED: fires.
- A mismatch in the middle of qualification restarts the count from 0.

Optional Feature:
- Macro DEBUGGER_TRIG_COUNT_EN.
- When defined:
  - Adds output `trig_count`, 16 bits, registered: the number of triggers since reset.
  - It increments in the same edge that sets trigger, saturates at 16'hFFFF and resets to 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset asserted with w=8'h55, then released -> trigger=0, data=8'h00 throughout and after (no match).
- Defaults, w goes 8'h00 -> 8'h20 at edge k and is held for 100 cycles -> trigger=1 only in the cycle after edge k, data=8'h20; no further pulse while w stays 8'h20.
- Defaults: w=8'h20, then 8'h00 for 1 cycle after HOLDOFF expires, then 8'h20 -> second single-cycle pulse; a pulse during HOLD never occurs.
- MATCH_LEN=3, w=8'h20 for 2 cycles, 8'h00, 8'h20 for 3 cycles -> no trigger on the first burst; one pulse after the third sample of the second burst.
- MASK=8'hF0, w=8'h2A -> trigger, data=8'h2A; w=8'h3A -> no trigger.
- Reset low for 1 cycle while trigger=1 -> trigger and data go to 0 asynchronously; with DEBUGGER_TRIG_COUNT_EN, trig_count returns to 0.

Source files
------------

// File: rtl/debugger_core.sv
// debugger_core: masked byte-pattern trigger with match qualification, holdoff and re-arm on clear.
// Optional macro DEBUGGER_TRIG_COUNT_EN adds the 16-bit saturating trig_count output.
`default_nettype none

module debugger_core #(
  parameter logic [7:0]  PATTERN   = 8'h20,
  parameter logic [7:0]  MASK      = 8'hFF,
  parameter int unsigned MATCH_LEN = 1,
  parameter int unsigned HOLDOFF   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  w,
  output logic        trigger,
  output logic [7:0]  data
`ifdef DEBUGGER_TRIG_COUNT_EN
  ,
  output logic [15:0] trig_count
`endif
);

  localparam logic [7:0] MLEN = 8'(MATCH_LEN);
  localparam logic [7:0] HOFF = 8'(HOLDOFF);

  typedef enum logic [1:0] {
    ARMED      = 2'd0,
    HOLD       = 2'd1,
    WAIT_CLEAR = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [7:0] match_cnt, match_cnt_nx;
  logic [7:0] hold_cnt, hold_cnt_nx;
  logic       match;
  logic       fire;

  assign match = ((w & MASK) == (PATTERN & MASK));

  always_comb begin
    state_nx     = state;
    match_cnt_nx = match_cnt;
    hold_cnt_nx  = hold_cnt;
    fire         = 1'b0;
    case (state)
      ARMED: begin
        if (!match) begin
          match_cnt_nx = 8'd0;
        end else if (match_cnt == MLEN - 8'd1) begin
          // Qualifying sample: counter saturates at MATCH_LEN while we leave ARMED.
          fire         = 1'b1;
          match_cnt_nx = MLEN;
          hold_cnt_nx  = 8'd0;
          state_nx     = (HOFF == 8'd0) ? WAIT_CLEAR : HOLD;
        end else begin
          match_cnt_nx = match_cnt + 8'd1;
        end
      end
      HOLD: begin
        if (hold_cnt == HOFF - 8'd1) begin
          hold_cnt_nx = 8'd0;
          state_nx    = WAIT_CLEAR;
        end else begin
          hold_cnt_nx = hold_cnt + 8'd1;
        end
      end
      WAIT_CLEAR: begin
        // A static matching level must drop once before the unit re-arms.
        if (!match) begin
          match_cnt_nx = 8'd0;
          state_nx     = ARMED;
        end
      end
      default: begin
        match_cnt_nx = 8'd0;
        hold_cnt_nx  = 8'd0;
        state_nx     = ARMED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARMED;
      match_cnt <= 8'd0;
      hold_cnt  <= 8'd0;
      trigger   <= 1'b0;
      data      <= 8'h00;
    end else begin
      state     <= state_nx;
      match_cnt <= match_cnt_nx;
      hold_cnt  <= hold_cnt_nx;
      trigger   <= fire;
      if (fire) begin
        data <= w;
      end
    end
  end

`ifdef DEBUGGER_TRIG_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_count <= 16'd0;
    end else if (fire && (trig_count != 16'hFFFF)) begin
      trig_count <= trig_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_debugger_core.sv
// tb_debugger_core: vector table, hand sequences and randomized run against a history-based reference model.
// Three instances: defaults, MATCH_LEN=3/HOLDOFF=2, MASK=8'hF0/HOLDOFF=0.
`default_nettype none

module tb_debugger_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] w = 8'h00;
  logic       trig0, trig1, trig2;
  logic [7:0] data0, data1, data2;
`ifdef DEBUGGER_TRIG_COUNT_EN
  logic [15:0] tc0, tc1, tc2;
`endif

  always #5 clk = ~clk;

  debugger_core u0 (
    .clk(clk), .reset(reset), .w(w), .trigger(trig0), .data(data0)
`ifdef DEBUGGER_TRIG_COUNT_EN
    , .trig_count(tc0)
`endif
  );

  debugger_core #(.MATCH_LEN(3), .HOLDOFF(2)) u1 (
    .clk(clk), .reset(reset), .w(w), .trigger(trig1), .data(data1)
`ifdef DEBUGGER_TRIG_COUNT_EN
    , .trig_count(tc1)
`endif
  );

  debugger_core #(.MASK(8'hF0), .HOLDOFF(0)) u2 (
    .clk(clk), .reset(reset), .w(w), .trigger(trig2), .data(data2)
`ifdef DEBUGGER_TRIG_COUNT_EN
    , .trig_count(tc2)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-instance sample history; a trigger fires when the run of
  // matching samples since the instance last re-armed reaches MATCH_LEN.
  int unsigned mlen_a [3] = '{1, 3, 1};
  int unsigned hoff_a [3] = '{4, 2, 0};
  logic [7:0]  mask_a [3] = '{8'hFF, 8'hFF, 8'hF0};
  bit          hist   [3][0:8191];
  bit          armed  [3];
  int          rearm  [3];
  int          clear_from [3];
  logic        e_trig [3];
  logic [7:0]  e_data [3];
  int          e_cnt  [3];
  int          n;

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      armed[i] = 1'b1;
      rearm[i] = 0;
      clear_from[i] = 0;
      e_trig[i] = 1'b0;
      e_data[i] = 8'h00;
      e_cnt[i] = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] wv);
    for (int i = 0; i < 3; i++) begin
      bit m;
      int run;
      m = ((wv & mask_a[i]) == (8'h20 & mask_a[i]));
      hist[i][n] = m;
      e_trig[i] = 1'b0;
      if (armed[i]) begin
        run = 0;
        for (int j = n; j >= rearm[i] && hist[i][j]; j--) run++;
        if (run >= int'(mlen_a[i])) begin
          e_trig[i] = 1'b1;
          e_data[i] = wv;
          if (e_cnt[i] < 65535) e_cnt[i]++;
          armed[i] = 1'b0;
          clear_from[i] = n + int'(hoff_a[i]) + 1;
        end
      end else if (n >= clear_from[i] && !m) begin
        armed[i] = 1'b1;
        rearm[i] = n + 1;
      end
    end
    if (n < 8191) n++;
  endtask

  task automatic check_all();
    chk("u0.trigger", {15'd0, trig0}, {15'd0, e_trig[0]});
    chk("u0.data", {8'd0, data0}, {8'd0, e_data[0]});
    chk("u1.trigger", {15'd0, trig1}, {15'd0, e_trig[1]});
    chk("u1.data", {8'd0, data1}, {8'd0, e_data[1]});
    chk("u2.trigger", {15'd0, trig2}, {15'd0, e_trig[2]});
    chk("u2.data", {8'd0, data2}, {8'd0, e_data[2]});
`ifdef DEBUGGER_TRIG_COUNT_EN
    chk("u0.trig_count", tc0, 16'(e_cnt[0]));
    chk("u1.trig_count", tc1, 16'(e_cnt[1]));
    chk("u2.trig_count", tc2, 16'(e_cnt[2]));
`endif
  endtask

  // Drive one cycle: inputs change 1 time unit after the edge, checks follow the next edge.
  task automatic cycle(input logic [7:0] wv, input logic rv);
    w = wv;
    reset = rv;
    @(posedge clk);
    #1;
    if (!rv) model_reset();
    else model_step(wv);
    check_all();
  endtask

  task automatic reset_all();
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] wv;
    logic       trig;
    logic [7:0] dat;
  } vec_t;

  vec_t vecs[$];
  int   pulses;

  initial begin
    // Defaults instance (MATCH_LEN=1, HOLDOFF=4): hand-derived expectations.
    vecs = '{
      '{1'b0, 8'h55, 1'b0, 8'h00}, '{1'b0, 8'h55, 1'b0, 8'h00},
      '{1'b1, 8'h55, 1'b0, 8'h00}, '{1'b1, 8'h00, 1'b0, 8'h00},
      '{1'b1, 8'h20, 1'b1, 8'h20}, '{1'b1, 8'h20, 1'b0, 8'h20},
      '{1'b1, 8'h00, 1'b0, 8'h20}, '{1'b1, 8'h20, 1'b0, 8'h20},
      '{1'b1, 8'h20, 1'b0, 8'h20}, '{1'b1, 8'h20, 1'b0, 8'h20},
      '{1'b1, 8'h00, 1'b0, 8'h20}, '{1'b1, 8'h20, 1'b1, 8'h20},
      '{1'b1, 8'h21, 1'b0, 8'h20}, '{1'b1, 8'h21, 1'b0, 8'h20},
      '{1'b1, 8'h21, 1'b0, 8'h20}, '{1'b1, 8'h21, 1'b0, 8'h20},
      '{1'b1, 8'h20, 1'b0, 8'h20}, '{1'b1, 8'h00, 1'b0, 8'h20},
      '{1'b1, 8'h20, 1'b1, 8'h20}
    };
    model_reset();
    foreach (vecs[i]) begin
      w = vecs[i].wv;
      reset = vecs[i].rst;
      @(posedge clk);
      #1;
      if (!vecs[i].rst) model_reset();
      else model_step(vecs[i].wv);
      chk($sformatf("vec%0d.trigger", i), {15'd0, trig0}, {15'd0, vecs[i].trig});
      chk($sformatf("vec%0d.data", i), {8'd0, data0}, {8'd0, vecs[i].dat});
    end

    // Static matching level held for 100 cycles fires exactly once.
    reset_all();
    cycle(8'h00, 1'b1);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(8'h20, 1'b1);
      if (trig0) pulses++;
      if (i == 0) chk("static.first_pulse", {15'd0, trig0}, 16'd1);
    end
    chk("static.pulses", 16'(pulses), 16'd1);
    chk("static.data", {8'd0, data0}, 16'h0020);

    // MATCH_LEN=3: broken burst does not fire, full burst fires once on its third sample.
    reset_all();
    pulses = 0;
    cycle(8'h20, 1'b1); if (trig1) pulses++;
    cycle(8'h20, 1'b1); if (trig1) pulses++;
    cycle(8'h00, 1'b1); if (trig1) pulses++;
    cycle(8'h20, 1'b1); if (trig1) pulses++;
    cycle(8'h20, 1'b1); if (trig1) pulses++;
    chk("len3.no_early", 16'(pulses), 16'd0);
    cycle(8'h20, 1'b1);
    chk("len3.fire", {15'd0, trig1}, 16'd1);
    chk("len3.data", {8'd0, data1}, 16'h0020);

    // MASK=F0: low nibble ignored, high nibble must match.
    reset_all();
    cycle(8'h2A, 1'b1);
    chk("mask.fire_2A", {15'd0, trig2}, 16'd1);
    chk("mask.data_2A", {8'd0, data2}, 16'h002A);
    cycle(8'h00, 1'b1);
    cycle(8'h3A, 1'b1);
    chk("mask.no_fire_3A", {15'd0, trig2}, 16'd0);
    chk("mask.data_held", {8'd0, data2}, 16'h002A);

    // Asynchronous reset while the trigger pulse is high.
    reset_all();
    cycle(8'h00, 1'b1);
    cycle(8'h20, 1'b1);
    chk("async.pulse_before", {15'd0, trig0}, 16'd1);
    #1 reset = 1'b0;
    #1;
    chk("async.trigger", {15'd0, trig0}, 16'd0);
    chk("async.data", {8'd0, data0}, 16'h0000);
`ifdef DEBUGGER_TRIG_COUNT_EN
    chk("async.trig_count", tc0, 16'd0);
`endif
    model_reset();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    reset = 1'b1;
    cycle(8'h20, 1'b1);
    chk("async.refire", {15'd0, trig0}, 16'd1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] wv;
      case ($urandom_range(0, 5))
        0, 1: wv = 8'h20;
        2:    wv = 8'h2A;
        3:    wv = 8'h3A;
        4:    wv = 8'h00;
        default: wv = 8'($urandom);
      endcase
      cycle(wv, ($urandom_range(0, 199) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
